shift_engine: RTL and testbench

Parametrised universal serial/parallel shift register that succeeds the fixed 16-bit SISO shifter. Generalises the width and adds a counted burst-shift engine: parallel load, then a Start/Busy/Done handshake that performs 0..WIDTH single-bit shifts left or right, with optional rotate. It sits between a parallel data source and a serial link or bit-serial datapath, exposing both the serial output and the full register contents.

---
 rtl/shift_engine.sv | 123 ++++++++++++
 tb/tb_shift_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_engine.sv
// shift_engine: universal shift register with a counted burst-shift engine.
// Optional rotate feedback is compiled in when ROTATE_EN is defined.
module shift_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] A,
    input  logic             Start,
    input  logic [CNT_W-1:0] Amount,
    input  logic             Left,
    input  logic             Rot,
    input  logic             Din,
    output logic             Dout,
    output logic [WIDTH-1:0] register,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] w_reg;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_n;
    logic             r_left;
    logic             w_left;
    logic             r_dout;
    logic             w_dout;
    logic             w_out;
    logic             w_in;

    assign w_n   = (Amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : Amount;
    assign w_out = r_left ? r_reg[WIDTH-1] : r_reg[0];

`ifdef ROTATE_EN
    logic r_rot;
    logic w_rot;

    assign w_in  = r_rot ? w_out : Din;
    assign w_rot = (r_state != SHIFT && !Load && Start) ? Rot : r_rot;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rot <= 1'b0;
        end else begin
            r_rot <= w_rot;
        end
    end
`else
    logic w_unused;

    assign w_in     = Din;
    assign w_unused = Rot;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_reg   <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_reg   <= w_reg;
            r_cnt   <= w_cnt;
            r_left  <= w_left;
            r_dout  <= w_dout;
        end
    end

    // DONE accepts Load/Start exactly like IDLE so bursts can chain.
    always_comb begin
        w_next = r_state;
        w_reg  = r_reg;
        w_cnt  = r_cnt;
        w_left = r_left;
        w_dout = r_dout;
        unique case (r_state)
            SHIFT: begin
                if (r_left) begin
                    w_reg = {r_reg[WIDTH-2:0], w_in};
                end else begin
                    w_reg = {w_in, r_reg[WIDTH-1:1]};
                end
                w_dout = w_out;
                w_cnt  = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_next = DONE;
                end
            end
            IDLE, DONE: begin
                w_next = IDLE;
                if (Load) begin
                    w_reg = A;
                end else if (Start) begin
                    w_left = Left;
                    w_cnt  = w_n;
                    w_next = (w_n == '0) ? DONE : SHIFT;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign Busy     = (r_state == SHIFT);
    assign Done     = (r_state == DONE);
    assign Dout     = r_dout;
    assign register = r_reg;

endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine: directed and randomized bursts against a
// whole-burst arithmetic reference model.
module tb_shift_engine;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Load;
    logic [15:0] A;
    logic        Start;
    logic [4:0]  Amount;
    logic        Left;
    logic        Rot;
    logic        Din;
    logic        Dout;
    logic [15:0] register;
    logic        Busy;
    logic        Done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_reg;
    logic        m_dout;

`ifdef ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    shift_engine dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Load     (Load),
        .A        (A),
        .Start    (Start),
        .Amount   (Amount),
        .Left     (Left),
        .Rot      (Rot),
        .Din      (Din),
        .Dout     (Dout),
        .register (register),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Whole burst as one wide shift of {register, fill}.
    function automatic logic [15:0] mdl(input logic [15:0] r, input int n,
                                        input bit l, input bit rt,
                                        input bit d);
        logic [31:0] full;
        logic [15:0] fill;
        fill = d ? 16'hFFFF : 16'h0000;
        if (rt && ROT_EN) fill = r;
        if (l) begin
            full = {r, fill} << n;
            return full[31:16];
        end
        full = {fill, r} >> n;
        return full[15:0];
    endfunction

    task automatic load(input logic [15:0] v);
        Load = 1'b1;
        A    = v;
        tick();
        Load = 1'b0;
        A    = $urandom;
        m_reg = v;
        chk("load_reg", register, v);
        chk("load_dout", Dout, m_dout);
    endtask

    task automatic burst(input logic [4:0] amt, input bit l, input bit rt,
                         input bit d, input bit b2b);
        int          n;
        logic [15:0] r0;
        logic [15:0] rx;
        n  = (amt > 5'd16) ? 16 : int'(amt);
        r0 = m_reg;
        rx = mdl(r0, n, l, rt, d);
        Start  = 1'b1;
        Amount = amt;
        Left   = l;
        Rot    = rt;
        Din    = d;
        tick();
        Start  = 1'b0;
        Amount = $urandom;
        Left   = ~l;
        Rot    = ~rt;
        if (n == 0) begin
            chk("z_busy", Busy, 0);
            chk("z_done", Done, 1);
            chk("z_reg", register, r0);
        end else begin
            for (int k = 1; k <= n; k++) begin
                chk("busy", Busy, 1);
                chk("no_done", Done, 0);
                tick();
                chk("dout", Dout, l ? r0[16-k] : r0[k-1]);
            end
            chk("end_busy", Busy, 0);
            chk("done", Done, 1);
            chk("reg", register, rx);
            m_dout = l ? r0[16-n] : r0[n-1];
        end
        m_reg = rx;
        if (!b2b) begin
            tick();
            chk("done_drop", Done, 0);
            chk("idle_busy", Busy, 0);
            chk("hold_reg", register, m_reg);
            chk("hold_dout", Dout, m_dout);
        end
    endtask

    initial begin
        Rst_n  = 1'b0;
        Load   = 1'b0;
        A      = '0;
        Start  = 1'b0;
        Amount = '0;
        Left   = 1'b0;
        Rot    = 1'b0;
        Din    = 1'b0;
        m_reg  = '0;
        m_dout = 1'b0;
        #12;
        chk("rst_reg", register, 0);
        chk("rst_dout", Dout, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();

        load(16'hA5A5);
        burst(5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_reg", register, 16'hF4B4);

        load(16'hABCD);
        burst(5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_reg", register, 16'h5E68);
        chk("t2_dout", Dout, 1);

        load(16'h8001);
        burst(5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rot1", register, ROT_EN ? 16'h0003 : 16'h0002);
        load(16'h8001);
        burst(5'd16, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rot16", register, ROT_EN ? 16'h8001 : 16'h0000);

        load(16'h1234);
        burst(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("zero_reg", register, 16'h1234);
        burst(5'd20, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clamp_reg", register, 16'hFFFF);

        load(16'h3C5A);
        burst(5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        burst(5'd5, 1'b1, 1'b1, 1'b1, 1'b0);

        load(16'h00FF);
        Start  = 1'b1;
        Amount = 5'd8;
        Left   = 1'b1;
        Din    = 1'b0;
        tick();
        Start = 1'b0;
        tick();
        chk("ab_s1", register, 16'h01FE);
        Load = 1'b1;
        A    = 16'hFFFF;
        tick();
        Load = 1'b0;
        chk("ab_ignored", register, 16'h03FC);
        chk("ab_busy", Busy, 1);
        tick();
        chk("ab_s3", register, 16'h07F8);
        Rst_n = 1'b0;
        #1;
        chk("ab_reg", register, 0);
        chk("ab_rbusy", Busy, 0);
        chk("ab_rdone", Done, 0);
        chk("ab_rdout", Dout, 0);
        m_reg  = '0;
        m_dout = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        load(16'h0F0F);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) load(16'($urandom));
            burst(5'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 2) == 0));
        end
        tick();
        chk("final_busy", Busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
